dm_arbiter: RTL
===============

# dm_arbiter

Two-requester arbiter in front of the data memory `dm`. It shares the single `dm` port between the CPU load/store unit (master 0) and the debug/DMA loader (master 1). Master 0 has fixed priority. An aging counter guarantees master 1 a slot after `MAX_WAIT` consecutive denied cycles. Read data is returned through a registered response channel, one cycle after the grant.

## Interface
Parameters:
- `AW`, 32: address width (word address, forwarded unchanged to `dm.addr`).
- `DW`, 32: data width.
- `MAX_WAIT`, 4: consecutive denied cycles of master 1 that force a grant to master 1 (range 1..15).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `m0_req` in 1: master 0 request valid.
- `m0_we` in 1: master 0 write (1) / read (0).
- `m0_addr` in AW: master 0 word address.
- `m0_wdata` in DW: master 0 write data.
- `m0_gnt` out 1: master 0 request accepted this cycle.
- `m0_rvalid` out 1: master 0 read data valid (registered).
- `m0_rdata` out DW: master 0 read data.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same as master 0, for master 1.
- `dm_addr` out AW: to `dm.addr`.
- `dm_ctrl_w` out 1: to `dm.ctrl_w`.
- `dm_ctrl_r` out 1: to `dm.ctrl_r`.
- `dm_wdata` out DW: to `dm.wdata`.
- `dm_rdata` in DW: from `dm.rdata`; combinational, valid in the same cycle as `dm_ctrl_r`.

## Operation
- Grant is combinational from the `req` inputs and registered state. At most one `gnt` is high per cycle. A request is accepted in the cycle its `gnt` is high; the requester may change or drop its request the next cycle.
- Priority rule:
  - If `force1` (age counter == `MAX_WAIT`) and `m1_req`: grant master 1.
  - Else if `m0_req`: grant master 0.
  - Else if `m1_req`: grant master 1.
  - Else: no grant.
- Memory port:
  - In a grant cycle, the `dm_*` signals carry the granted master's fields.
  - `dm_ctrl_w` = `we`, `dm_ctrl_r` = !`we`.
  - With no grant: `dm_ctrl_w` = `dm_ctrl_r` = 0; `dm_addr` and `dm_wdata` are 0.
- Age counter (4 bits):
  - Increments when `m1_req` is high and `m1_gnt` is low, saturating at `MAX_WAIT`.
  - Clears to 0 when `m1_gnt` is high or `m1_req` is low.
- Response FSM per master, states IDLE and RESP:
  - IDLE→RESP on a granted read. The `dm_rdata` value is captured into `mX_rdata`.
  - RESP drives `mX_rvalid` = 1 for exactly one cycle.
  - RESP→RESP if another granted read occurs in the RESP cycle (back-to-back, one response per cycle).
  - RESP→IDLE otherwise.
  - Writes produce no response.
- `mX_rdata` holds its last captured value until the next read of that master. It is not cleared on return to IDLE.
- No response backpressure: a master must be able to accept `rvalid` at any cycle.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - age counter = 0.
  - Both FSMs go to IDLE.
  - `m0_rvalid` = `m1_rvalid` = 0.
  - `m0_rdata` = `m1_rdata` = 0.
- During reset, `gnt` and `dm_ctrl_*` are forced to 0, so no write is issued to `dm`.
- Reset mid-read: a response pending for the next cycle is dropped and `rvalid` stays 0.
- Read latency: grant in cycle N, then `rvalid`/`rdata` in cycle N+1.
- Write latency: `dm` is updated at the rising edge ending cycle N.
- Throughput: one access per cycle total.
- With both masters requesting continuously, master 1 is granted once every `MAX_WAIT`+1 cycles.
- Forced master-1 grant cycle: `m0_gnt` = 0 even if `m0_req` = 1. Master 0 must hold its request.
- Simultaneous events: in the same cycle, a granted read of master 0 and a pending master-1 response are independent. Both `rvalid` outputs may be high together.

## Structure
- Package `dm_arb_pkg`:
  - `AW`/`DW` defaults.
  - Master-ID constants `M_CPU` = 0, `M_DBG` = 1.
  - Response FSM state constants `RSP_IDLE`, `RSP_RESP`.
- Sub-module `dm_arb_age_cnt`:
  - Saturating 4-bit counter with inputs `inc`, `clr` and output `force`.
  - One instance, for master 1.
- Response FSM: written twice inline (or generated), not a separate module.

## Test plan
- Reset hold, then release with no requests → all `gnt`/`rvalid`/`dm_ctrl_*` = 0 and both `rdata` = 0.
- M0 writes 32 to addr 0, then 64 to addr 1, then reads addr 1 → `dm_ctrl_w` pulses in the write cycles; `m0_rvalid` = 1 with `m0_rdata` = 64 one cycle after the read grant.
- `m0_req` and `m1_req` held high for 12 cycles with `MAX_WAIT`=4 → `m1_gnt` in cycles 5 and 10 only; `m0_gnt` in all other cycles; never both high.
- M1 alone reads addr 0 on consecutive cycles → `m1_rvalid` high for two consecutive cycles, each with `m1_rdata` = 32.
- M0 read granted, `rst_n` low in the following cycle → `m0_rvalid` stays 0; age counter is 0 after release.
- M0 reads addr 1 while an M1 read response is pending → both `rvalid` high in the same cycle with correct, independent data.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared constants for the data-memory arbiter: default bus widths,
// requester IDs and the read-response state encoding.
package dm_arb_pkg;

    localparam int DM_AW = 32;
    localparam int DM_DW = 32;

    localparam int M_CPU = 0;
    localparam int M_DBG = 1;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_RESP = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of both requester channels plus the shared data-memory port.
// The arbiter takes the slave side; requesters and the memory sit on the master side.
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int AW = DM_AW,
    parameter int DW = DM_DW
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] dm_addr;
    logic          dm_ctrl_w;
    logic          dm_ctrl_r;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output dm_addr, dm_ctrl_w, dm_ctrl_r, dm_wdata,
        input  dm_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  dm_addr, dm_ctrl_w, dm_ctrl_r, dm_wdata,
        output dm_rdata
    );

endinterface

// File: rtl/dm_arb_age_cnt.sv
// Saturating 4-bit wait counter; o_force flags that the starved requester
// has waited MAX_WAIT consecutive cycles and must win the next arbitration.
module dm_arb_age_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_force
);
    localparam logic [3:0] SAT = 4'(MAX_WAIT);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != SAT)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_force = (r_cnt == SAT);

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter in front of the data memory: fixed priority for the CPU,
// aging guarantee for the debug loader, one-cycle registered read responses.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW       = DM_AW,
    parameter int DW       = DM_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    dm_arbiter_if.slave  bus
);
    logic [1:0]    w_gnt;
    logic [1:0]    w_we;
    logic [1:0]    w_rvalid;
    logic [DW-1:0] w_rdata [2];
    logic          w_force;

    assign w_we = {bus.m1_we, bus.m0_we};

    dm_arb_age_cnt #(.MAX_WAIT(MAX_WAIT)) u_age (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (bus.m1_req & ~w_gnt[M_DBG]),
        .i_clr   (w_gnt[M_DBG] | ~bus.m1_req),
        .o_force (w_force)
    );

    // Grants are suppressed while reset is asserted so no write reaches memory.
    always_comb begin
        w_gnt = 2'b00;
        if (rst_n) begin
            if (w_force && bus.m1_req) begin
                w_gnt[M_DBG] = 1'b1;
            end else if (bus.m0_req) begin
                w_gnt[M_CPU] = 1'b1;
            end else if (bus.m1_req) begin
                w_gnt[M_DBG] = 1'b1;
            end
        end
    end

    always_comb begin
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.dm_ctrl_w = 1'b0;
        bus.dm_ctrl_r = 1'b0;
        if (w_gnt[M_CPU]) begin
            bus.dm_addr   = bus.m0_addr;
            bus.dm_wdata  = bus.m0_wdata;
            bus.dm_ctrl_w = bus.m0_we;
            bus.dm_ctrl_r = ~bus.m0_we;
        end else if (w_gnt[M_DBG]) begin
            bus.dm_addr   = bus.m1_addr;
            bus.dm_wdata  = bus.m1_wdata;
            bus.dm_ctrl_w = bus.m1_we;
            bus.dm_ctrl_r = ~bus.m1_we;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_rsp
        rsp_state_t    r_state;
        rsp_state_t    w_state_nxt;
        logic [DW-1:0] r_rdata;
        logic          w_rd;

        assign w_rd = w_gnt[g] & ~w_we[g];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state <= RSP_IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // From either state a granted read (re)enters RESP; anything else idles.
        always_comb begin
            w_state_nxt = RSP_IDLE;
            if (w_rd) begin
                w_state_nxt = RSP_RESP;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_rdata <= '0;
            end else if (w_rd) begin
                r_rdata <= bus.dm_rdata;
            end
        end

        // Gating with rst_n drops a response that is due in a reset cycle.
        assign w_rvalid[g] = (r_state == RSP_RESP) & rst_n;
        assign w_rdata[g]  = r_rdata;
    end

    assign bus.m0_gnt    = w_gnt[M_CPU];
    assign bus.m1_gnt    = w_gnt[M_DBG];
    assign bus.m0_rvalid = w_rvalid[M_CPU];
    assign bus.m1_rvalid = w_rvalid[M_DBG];
    assign bus.m0_rdata  = w_rdata[M_CPU];
    assign bus.m1_rdata  = w_rdata[M_DBG];

endmodule
